// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port synchronous video RAM between VGA scan-out and two
// game-logic requesters (A: tank renderer, B: bullet/map renderer).
// VGA reads always win. A and B split the remaining slots round-robin.
// At most one memory command is issued per clock, and every output is registered.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   vga_rd_i/addr_i      VGA read request and address (no handshake)
//   vga_data_o/valid_o   VGA read data and its one-cycle strobe
//   req_x_i, we_x_i      requester x pending transaction, 1 = write
//   addr_x_i, wdata_x_i  requester x address and write data
//   gnt_x_o              requester x command is on the memory bus this cycle
//   rdata_x_o/rvalid_x_o requester x read data and its one-cycle strobe
//   mem_en_o, mem_we_o   RAM enable and write enable
//   mem_addr_o/wdata_o   RAM address and write data
//   mem_rdata_i          RAM read data, valid the cycle after a read command
module vram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vga_rd_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic [DATA_W-1:0] vga_data_o,
  output logic              vga_valid_o,
  input  logic              req_a_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] wdata_a_i,
  output logic              gnt_a_o,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic              rvalid_a_o,
  input  logic              req_b_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] wdata_b_i,
  output logic              gnt_b_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic              rvalid_b_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_A, TAG_B} tag_e;
  typedef enum logic {RR_A, RR_B} rr_e;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  rr_e               rr_q, rr_d;
  tag_e              tag0_q, tag0_d;
  tag_e              tag1_q;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic              vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              rvalid_b_q, rvalid_b_d;

  logic elig_a, elig_b, pick_a, pick_b;

  always_comb begin
    // A request granted last cycle has been consumed, so it cannot win twice in a row.
    elig_a = req_a_i & ~gnt_a_q;
    elig_b = req_b_i & ~gnt_b_q;
    pick_a = elig_a & (~elig_b | (rr_q == RR_A));
    pick_b = elig_b & ~pick_a;

    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    rr_d        = rr_q;
    tag0_d      = TAG_NONE;

    if (vga_rd_i) begin
      mem_en_d   = 1'b1;
      mem_addr_d = vga_addr_i;
      tag0_d     = TAG_VGA;
    end else if (pick_a) begin
      mem_en_d    = 1'b1;
      mem_we_d    = we_a_i;
      mem_addr_d  = addr_a_i;
      mem_wdata_d = wdata_a_i;
      gnt_a_d     = 1'b1;
      rr_d        = RR_B;
      tag0_d      = we_a_i ? TAG_NONE : TAG_A;
    end else if (pick_b) begin
      mem_en_d    = 1'b1;
      mem_we_d    = we_b_i;
      mem_addr_d  = addr_b_i;
      mem_wdata_d = wdata_b_i;
      gnt_b_d     = 1'b1;
      rr_d        = RR_A;
      tag0_d      = we_b_i ? TAG_NONE : TAG_B;
    end

    // tag1_q marks the cycle in which mem_rdata_i belongs to an earlier read.
    vga_valid_d = (tag1_q == TAG_VGA);
    rvalid_a_d  = (tag1_q == TAG_A);
    rvalid_b_d  = (tag1_q == TAG_B);
    vga_data_d  = vga_valid_d ? mem_rdata_i : vga_data_q;
    rdata_a_d   = rvalid_a_d  ? mem_rdata_i : rdata_a_q;
    rdata_b_d   = rvalid_b_d  ? mem_rdata_i : rdata_b_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      rr_q        <= RR_A;
      tag0_q      <= TAG_NONE;
      tag1_q      <= TAG_NONE;
      vga_data_q  <= '0;
      vga_valid_q <= 1'b0;
      rdata_a_q   <= '0;
      rvalid_a_q  <= 1'b0;
      rdata_b_q   <= '0;
      rvalid_b_q  <= 1'b0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      rr_q        <= rr_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag0_q;
      vga_data_q  <= vga_data_d;
      vga_valid_q <= vga_valid_d;
      rdata_a_q   <= rdata_a_d;
      rvalid_a_q  <= rvalid_a_d;
      rdata_b_q   <= rdata_b_d;
      rvalid_b_q  <= rvalid_b_d;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign gnt_a_o     = gnt_a_q;
  assign gnt_b_o     = gnt_b_q;
  assign vga_data_o  = vga_data_q;
  assign vga_valid_o = vga_valid_q;
  assign rdata_a_o   = rdata_a_q;
  assign rvalid_a_o  = rvalid_a_q;
  assign rdata_b_o   = rdata_b_q;
  assign rvalid_b_o  = rvalid_b_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Scoreboard bench for vram_arbiter. Stimulus pushes the expected memory
// commands and read returns into queues. A negedge monitor pops and compares
// them whenever the arbiter drives mem_en or a valid strobe. A small RAM model
// answers reads one cycle after the command.
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 12;
  localparam int K_VGA = 0;
  localparam int K_A = 1;
  localparam int K_B = 2;

  logic clk = 1'b0;
  logic rstN;
  logic vgaRd;
  logic [AW-1:0] vgaAddr;
  logic [DW-1:0] vgaData;
  logic vgaValid;
  logic reqA, weA, gntA, rvalidA;
  logic [AW-1:0] addrA;
  logic [DW-1:0] wdataA, rdataA;
  logic reqB, weB, gntB, rvalidB;
  logic [AW-1:0] addrB;
  logic [DW-1:0] wdataB, rdataB;
  logic memEn, memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata, memRdata;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int p;
  logic prevGntA = 1'b0;
  logic prevGntB = 1'b0;

  typedef struct {
    int kind;
    logic we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int cyc;
  } cmd_t;

  typedef struct {
    int kind;
    logic [DW-1:0] data;
    int cyc;
  } ret_t;

  cmd_t cmdQ[$];
  ret_t retQ[$];

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .vga_rd_i(vgaRd), .vga_addr_i(vgaAddr), .vga_data_o(vgaData), .vga_valid_o(vgaValid),
    .req_a_i(reqA), .we_a_i(weA), .addr_a_i(addrA), .wdata_a_i(wdataA),
    .gnt_a_o(gntA), .rdata_a_o(rdataA), .rvalid_a_o(rvalidA),
    .req_b_i(reqB), .we_b_i(weB), .addr_b_i(addrB), .wdata_b_i(wdataB),
    .gnt_b_o(gntB), .rdata_b_o(rdataB), .rvalid_b_o(rvalidB),
    .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata), .mem_rdata_i(memRdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Fixed RAM contents: a few hand-picked words, an address-derived pattern elsewhere.
  function automatic logic [DW-1:0] ramWord(input logic [AW-1:0] a);
    case (a)
      15'h0001: return 12'h111;
      15'h0002: return 12'h222;
      15'h0003: return 12'h333;
      15'h0010: return 12'hABC;
      default:  return a[11:0] ^ 12'hC3C;
    endcase
  endfunction

  always @(posedge clk) begin
    if (memEn && !memWe) memRdata <= ramWord(memAddr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkRet(input int kind, input logic [DW-1:0] data);
    ret_t r;
    if (retQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL ret_unexpected actual=kind%0d required=none", kind);
    end else begin
      r = retQ.pop_front();
      checkOutput("ret_kind", kind, r.kind);
      checkOutput("ret_data", data, r.data);
      checkOutput("ret_cycle", cyc, r.cyc);
    end
  endtask

  task automatic pushCmd(input int kind, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int c);
    cmd_t e;
    e.kind = kind; e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = c;
    cmdQ.push_back(e);
  endtask

  task automatic pushRet(input int kind, input logic [DW-1:0] data, input int c);
    ret_t e;
    e.kind = kind; e.data = data; e.cyc = c;
    retQ.push_back(e);
  endtask

  // Waits the given number of rising edges, then drives every request input 1 time unit later.
  task automatic applyStimulus(input int waitCycles,
                               input logic vr, input logic [AW-1:0] va,
                               input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                               input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    repeat (waitCycles) @(posedge clk);
    #1;
    vgaRd = vr; vgaAddr = va;
    reqA = ra; weA = wa; addrA = aa; wdataA = da;
    reqB = rb; weB = wb; addrB = ab; wdataB = db;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_en"}, memEn, 0);
    checkOutput({tag, "_mem_we"}, memWe, 0);
    checkOutput({tag, "_mem_addr"}, memAddr, 0);
    checkOutput({tag, "_mem_wdata"}, memWdata, 0);
    checkOutput({tag, "_gnt_a"}, gntA, 0);
    checkOutput({tag, "_gnt_b"}, gntB, 0);
    checkOutput({tag, "_vga_valid"}, vgaValid, 0);
    checkOutput({tag, "_vga_data"}, vgaData, 0);
    checkOutput({tag, "_rvalid_a"}, rvalidA, 0);
    checkOutput({tag, "_rdata_a"}, rdataA, 0);
    checkOutput({tag, "_rvalid_b"}, rvalidB, 0);
    checkOutput({tag, "_rdata_b"}, rdataB, 0);
  endtask

  // Monitor: every bus command and every return strobe must match the head of its queue.
  always @(negedge clk) begin
    cmd_t c;
    if (memEn) begin
      if (cmdQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL cmd_unexpected actual=addr%0h required=none", memAddr);
      end else begin
        c = cmdQ.pop_front();
        checkOutput("cmd_cycle", cyc, c.cyc);
        checkOutput("cmd_gnt_a", gntA, c.kind == K_A);
        checkOutput("cmd_gnt_b", gntB, c.kind == K_B);
        checkOutput("cmd_we", memWe, c.we);
        checkOutput("cmd_addr", memAddr, c.addr);
        if (c.we) checkOutput("cmd_wdata", memWdata, c.wdata);
      end
    end else begin
      checkOutput("idle_gnt", {gntA, gntB}, 0);
    end
    if (gntA) checkOutput("gnt_a_b2b", prevGntA, 0);
    if (gntB) checkOutput("gnt_b_b2b", prevGntB, 0);
    prevGntA <= gntA;
    prevGntB <= gntB;
    if (vgaValid) checkRet(K_VGA, vgaData);
    if (rvalidA) checkRet(K_A, rdataA);
    if (rvalidB) checkRet(K_B, rdataB);
  end

  initial begin
    // Reset with every request asserted: outputs stay at zero.
    rstN = 1'b0;
    vgaRd = 1'b1; vgaAddr = 15'h0055;
    reqA = 1'b1; weA = 1'b1; addrA = 15'h0100; wdataA = 12'h5A1;
    reqB = 1'b1; weB = 1'b1; addrB = 15'h0200; wdataB = 12'h5B2;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");

    // Release with A and B contending: pointer starts at A, then strict alternation.
    applyStimulus(0, 0, 15'h0, 1, 1, 15'h0100, 12'h5A1, 1, 1, 15'h0200, 12'h5B2);
    rstN = 1'b1;
    p = cyc;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) pushCmd(K_A, 1'b1, 15'h0100, 12'h5A1, p + 1 + k);
      else            pushCmd(K_B, 1'b1, 15'h0200, 12'h5B2, p + 1 + k);
    end
    applyStimulus(6, 0, 15'h0, 0, 0, 15'h0, 12'h0, 0, 0, 15'h0, 12'h0);

    // Single VGA read: command next cycle, data three cycles after the request.
    applyStimulus(2, 1, 15'h0010, 0, 0, 15'h0, 12'h0, 0, 0, 15'h0, 12'h0);
    p = cyc;
    pushCmd(K_VGA, 1'b0, 15'h0010, 12'h0, p + 1);
    pushRet(K_VGA, 12'hABC, p + 3);
    applyStimulus(1, 0, 15'h0, 0, 0, 15'h0, 12'h0, 0, 0, 15'h0, 12'h0);

    // 640-cycle VGA burst while A waits with a write; A wins right after the burst.
    applyStimulus(2, 1, 15'h1000, 1, 1, 15'h0300, 12'h777, 0, 0, 15'h0, 12'h0);
    p = cyc;
    for (int k = 0; k < 640; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        vgaAddr = 15'h1000 + 15'(k);
      end
      pushCmd(K_VGA, 1'b0, 15'h1000 + 15'(k), 12'h0, p + 1 + k);
      pushRet(K_VGA, 12'(k) ^ 12'hC3C, p + 3 + k);
    end
    applyStimulus(1, 0, 15'h0, 1, 1, 15'h0300, 12'h777, 0, 0, 15'h0, 12'h0);
    pushCmd(K_A, 1'b1, 15'h0300, 12'h777, p + 641);
    applyStimulus(1, 0, 15'h0, 0, 0, 15'h0, 12'h0, 0, 0, 15'h0, 12'h0);

    // Interleaved VGA, A and B reads: each return lands on its own client only.
    applyStimulus(3, 1, 15'h0001, 1, 0, 15'h0002, 12'h0, 0, 0, 15'h0, 12'h0);
    p = cyc;
    pushCmd(K_VGA, 1'b0, 15'h0001, 12'h0, p + 1);
    pushRet(K_VGA, 12'h111, p + 3);
    applyStimulus(1, 0, 15'h0, 1, 0, 15'h0002, 12'h0, 0, 0, 15'h0, 12'h0);
    pushCmd(K_A, 1'b0, 15'h0002, 12'h0, p + 2);
    pushRet(K_A, 12'h222, p + 4);
    applyStimulus(1, 0, 15'h0, 0, 0, 15'h0, 12'h0, 1, 0, 15'h0003, 12'h0);
    pushCmd(K_B, 1'b0, 15'h0003, 12'h0, p + 3);
    pushRet(K_B, 12'h333, p + 5);
    applyStimulus(1, 0, 15'h0, 0, 0, 15'h0, 12'h0, 0, 0, 15'h0, 12'h0);

    // Reset one cycle after an A read grant: outputs clear at once, no return follows.
    applyStimulus(4, 0, 15'h0, 1, 0, 15'h0004, 12'h0, 0, 0, 15'h0, 12'h0);
    p = cyc;
    pushCmd(K_A, 1'b0, 15'h0004, 12'h0, p + 1);
    applyStimulus(1, 0, 15'h0, 0, 0, 15'h0, 12'h0, 0, 0, 15'h0, 12'h0);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkAllZero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    checkOutput("cmd_queue_drained", cmdQ.size(), 0);
    checkOutput("ret_queue_drained", retQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
